// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester bridge.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// APB bus bundle between the requester bridge and one completer.
interface apb_master_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_wait_timer.sv
// ACCESS wait-state counter; expired flags the cycle whose edge reaches TIMEOUT waits.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // TIMEOUT of zero disables the abort entirely.
  if (TIMEOUT == 0) begin : g_no_timeout
    assign expired = 1'b0;
  end else begin : g_timeout
    assign expired = en && (cnt_q == CntW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Turns a local valid/ready command into one APB SETUP/ACCESS transfer with a response pulse.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  apb_master_bridge_if.master apb
);

  apb_state_t        state_q;
  logic              psel_q, penable_q, pwrite_q, busy_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q, rsp_rdata_q;
  logic              rsp_valid_q, rsp_err_q, rsp_timeout_q;
  logic              accept, wait_en, expired;

  // presetn is active-high despite its name.
  assign cmd_ready = (state_q == APB_IDLE) && !presetn;
  assign accept    = cmd_valid && cmd_ready;
  assign wait_en   = (state_q == APB_ACCESS) && !apb.pready;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (pclk),
    .rst     (presetn),
    .clr     (accept),
    .en      (wait_en),
    .expired (expired)
  );

  always_ff @(posedge pclk) begin
    if (presetn) begin
      state_q       <= APB_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        APB_IDLE: begin
          if (accept) begin
            state_q  <= APB_SETUP;
            psel_q   <= 1'b1;
            busy_q   <= 1'b1;
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_wdata;
          end
        end
        APB_SETUP: begin
          state_q   <= APB_ACCESS;
          penable_q <= 1'b1;
        end
        APB_ACCESS: begin
          // pready wins over a timeout expiring on the same edge.
          if (apb.pready) begin
            state_q       <= APB_IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            busy_q        <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= apb.pslverr;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= (!pwrite_q && !apb.pslverr) ? apb.prdata : '0;
          end else if (expired) begin
            state_q       <= APB_IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            busy_q        <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
          end
        end
        default: begin
          state_q   <= APB_IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge against a transaction-level timing model.
module tb_apb_master_bridge;

  localparam int unsigned TO = 4;
  localparam int MaxTx = 2048;

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          w;       // wait states the completer inserts before pready
    bit          err;
    int          rst_at;  // ACCESS cycle index at which to pulse reset, -1 for none
  } item_t;

  logic        clk = 1'b0;
  logic        presetn;
  logic        cmd_valid, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy;
  logic [31:0] rsp_rdata;

  apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master_bridge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .pclk        (clk),
    .presetn     (presetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .apb         (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: one transfer in flight, k = cycles since the accepting edge.
  bit    act;
  int    k, a, cyc, ntx, cur_id;
  item_t cur;
  item_t dq[$];
  bit    rst_cur, rnd_phase;
  logic [31:0] e_addr, e_wdata, e_rdata;
  bit    e_write, e_err, e_to;
  int    acc_cyc[MaxTx];
  int    obs_cyc[MaxTx];
  logic [31:0] obs_rdata[MaxTx];
  bit    obs_err[MaxTx];
  bit    obs_to[MaxTx];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    act = 0; k = 0; a = 0;
    e_addr = '0; e_wdata = '0; e_rdata = '0;
    e_write = 0; e_err = 0; e_to = 0;
  endtask

  task automatic step();
    bit setup, access, resp_now, do_rst;
    int j;
    item_t it;
    @(negedge clk);
    cyc++;
    resp_now = act && (k == 2 + a);
    setup    = act && (k == 1);
    access   = act && (k >= 2) && (k < 2 + a);
    chk("psel", {63'd0, bus.psel}, {63'd0, setup || access});
    chk("penable", {63'd0, bus.penable}, {63'd0, access});
    chk("busy", {63'd0, busy}, {63'd0, setup || access});
    chk("cmd_ready", {63'd0, cmd_ready}, {63'd0, !(setup || access) && !rst_cur});
    chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, resp_now});
    chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e_rdata});
    chk("rsp_err", {63'd0, rsp_err}, {63'd0, e_err});
    chk("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, e_to});
    chk("paddr", {32'd0, bus.paddr}, {32'd0, e_addr});
    chk("pwdata", {32'd0, bus.pwdata}, {32'd0, e_wdata});
    chk("pwrite", {63'd0, bus.pwrite}, {63'd0, e_write});
    if (rsp_valid && act && cur_id < MaxTx) begin
      obs_cyc[cur_id]   = cyc;
      obs_rdata[cur_id] = rsp_rdata;
      obs_err[cur_id]   = rsp_err;
      obs_to[cur_id]    = rsp_timeout;
    end

    // Drive inputs for the edge that ends this cycle.
    do_rst = 0;
    if (access && cur.rst_at >= 0 && (k - 2) == cur.rst_at) do_rst = 1;
    if (rnd_phase && $urandom_range(0, 59) == 0) do_rst = 1;
    if (access && (k - 2) == cur.w) begin
      bus.pready  = 1'b1;
      bus.pslverr = cur.err;
      bus.prdata  = cur.rdata;
    end else begin
      bus.pready  = access ? 1'b0 : 1'($urandom_range(0, 1));
      bus.pslverr = 1'($urandom_range(0, 1));
      bus.prdata  = $urandom;
    end
    if (dq.size() != 0) begin
      cmd_valid = 1'b1;
      cmd_write = dq[0].write;
      cmd_addr  = dq[0].addr;
      cmd_wdata = dq[0].wdata;
    end else begin
      cmd_valid = rnd_phase ? ($urandom_range(0, 2) != 0) : 1'b0;
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
    end
    presetn = do_rst;
    rst_cur = do_rst;

    // Advance the model across the edge.
    if (do_rst) begin
      model_reset();
    end else if (act && k < 2 + a) begin
      k++;
      if (k == 2 + a) begin
        if (cur.w < int'(TO)) begin
          e_err   = cur.err;
          e_to    = 0;
          e_rdata = (!cur.write && !cur.err) ? cur.rdata : 32'd0;
        end else begin
          e_err = 1; e_to = 1; e_rdata = 32'd0;
        end
      end
    end else begin
      act = 0;
      if (cmd_valid) begin
        if (dq.size() != 0) begin
          it = dq.pop_front();
        end else begin
          it.write  = cmd_write;
          it.addr   = cmd_addr;
          it.wdata  = cmd_wdata;
          it.rdata  = $urandom;
          it.w      = $urandom_range(0, 6);
          it.err    = ($urandom_range(0, 3) == 0);
          it.rst_at = -1;
        end
        cur = it;
        a   = (cur.w < int'(TO)) ? cur.w + 1 : int'(TO);
        act = 1; k = 1;
        e_addr = cur.addr; e_wdata = cur.wdata; e_write = cur.write;
        cur_id = ntx;
        if (ntx < MaxTx) acc_cyc[ntx] = cyc;
        ntx++;
      end
    end
  endtask

  function automatic item_t mk(bit wr, logic [31:0] ad, logic [31:0] wd, logic [31:0] rd,
                               int w, bit er, int ra);
    item_t it;
    it.write = wr; it.addr = ad; it.wdata = wd; it.rdata = rd;
    it.w = w; it.err = er; it.rst_at = ra;
    return it;
  endfunction

  initial begin
    int guard;
    for (int i = 0; i < MaxTx; i++) obs_cyc[i] = -1;
    presetn = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = '0;
    rst_cur = 1; rnd_phase = 0; cyc = 0; ntx = 0; cur_id = 0;
    cur = mk(0, 0, 0, 0, 0, 0, -1);
    model_reset();
    repeat (2) @(posedge clk);

    dq.push_back(mk(1, 32'h3,   32'hDEADBEEF, 32'h0,        0, 0, -1));
    dq.push_back(mk(0, 32'h1,   32'h0,        32'h12345678, 2, 0, -1));
    dq.push_back(mk(0, 32'h800, 32'h0,        32'hCAFEF00D, 0, 1, -1));
    dq.push_back(mk(0, 32'h44,  32'h0,        32'h55AA55AA, 4, 0, -1));
    dq.push_back(mk(0, 32'h48,  32'h0,        32'hA5A5A5A5, 3, 0, -1));
    dq.push_back(mk(1, 32'h4C,  32'h11111111, 32'h0,        5, 0, 1));
    dq.push_back(mk(1, 32'h0,   32'h00000A00, 32'h0,        0, 0, -1));
    dq.push_back(mk(1, 32'h1,   32'h00000A01, 32'h0,        0, 0, -1));
    dq.push_back(mk(1, 32'h2,   32'h00000A02, 32'h0,        0, 0, -1));

    guard = 0;
    while ((dq.size() != 0 || act) && guard < 300) begin
      step();
      guard++;
    end
    if (guard >= 300) begin
      failures++;
      $display("FAIL directed_timeout got=%0d exp=<300", guard);
    end
    repeat (3) step();

    chk("lat_write0", 64'(obs_cyc[0] - acc_cyc[0]), 64'd3);
    chk("err_write0", {63'd0, obs_err[0]}, 64'd0);
    chk("lat_read_w2", 64'(obs_cyc[1] - acc_cyc[1]), 64'd5);
    chk("rdata_read_w2", {32'd0, obs_rdata[1]}, 64'h12345678);
    chk("slverr_err", {63'd0, obs_err[2]}, 64'd1);
    chk("slverr_to", {63'd0, obs_to[2]}, 64'd0);
    chk("slverr_rdata", {32'd0, obs_rdata[2]}, 64'd0);
    chk("lat_timeout", 64'(obs_cyc[3] - acc_cyc[3]), 64'd6);
    chk("timeout_flag", {63'd0, obs_to[3]}, 64'd1);
    chk("timeout_err", {63'd0, obs_err[3]}, 64'd1);
    chk("late_ready_lat", 64'(obs_cyc[4] - acc_cyc[4]), 64'd6);
    chk("late_ready_to", {63'd0, obs_to[4]}, 64'd0);
    chk("late_ready_rdata", {32'd0, obs_rdata[4]}, 64'hA5A5A5A5);
    chk("reset_no_rsp", 64'(obs_cyc[5]), 64'(-1));
    chk("b2b_gap1", 64'(acc_cyc[7] - acc_cyc[6]), 64'd3);
    chk("b2b_gap2", 64'(acc_cyc[8] - acc_cyc[7]), 64'd3);
    chk("b2b_lat", 64'(obs_cyc[8] - acc_cyc[8]), 64'd3);

    rnd_phase = 1;
    repeat (4000) step();
    rnd_phase = 0;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB requester (initiator) for the on-chip APB peripherals; converts a local valid/ready command into one APB SETUP/ACCESS transfer.
- Returns a one-cycle response pulse carrying read data, error and timeout flags.
- Sits between local control logic (CPU stub or testbench sequencer) and the peripheral's APB port.
- Supports one outstanding transfer at a time.

Parameters:
ADDR_W, 32, width of paddr/cmd_addr
DATA_W, 32, width of pwdata/prdata/cmd_wdata/rsp_rdata
TIMEOUT, 16, maximum ACCESS cycles with pready low before abort; 0 disables the timeout

Ports:
pclk  in  1  clock, all logic on rising edge
presetn  in  1  synchronous, active-high reset (asserted = 1) despite the name
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  pslverr seen or timeout
rsp_timeout  out  1  transfer aborted by timeout
busy  out  1  state != IDLE
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data (may be Z outside ACCESS)
pready  in  1  APB completer ready
pslverr  in  1  APB completer error

Behaviour:
- Reset (presetn=1 at an edge): state=IDLE. psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, busy = 0. paddr, pwdata, rsp_rdata = 0. Wait counter = 0. Reset has priority over every other event.
- All outputs are registered except cmd_ready, which is (state==IDLE) & !presetn.
- IDLE:
  - psel=0, penable=0.
  - On cmd_valid&cmd_ready: latch cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata, then go to SETUP.
  - Commands are not queued; cmd_valid in other states is held off by cmd_ready=0.
- SETUP:
  - psel=1, penable=0 for exactly one cycle, then go to ACCESS unconditionally.
- ACCESS:
  - psel=1, penable=1. paddr, pwrite and pwdata stay stable from SETUP until exit.
  - If pready=1 at an edge:
    - Go to IDLE; psel and penable drop at that edge.
    - rsp_valid=1 for the following cycle.
    - rsp_err=pslverr and rsp_timeout=0.
    - rsp_rdata = prdata if read and !pslverr, else 0.
  - If pready=0: increment the wait counter.
    - When TIMEOUT!=0 and the counter reaches TIMEOUT with pready still 0, go to IDLE with rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
    - pready=1 on the same edge as timeout expiry counts as a normal completion.
- pslverr and prdata are sampled only in ACCESS with pready=1. Z/X on prdata elsewhere must not propagate.
- Zero-wait latency:
  - Command accepted at edge 0; SETUP during cycle 1; ACCESS during cycle 2; rsp_valid during cycle 3.
  - A new command may be accepted in the rsp_valid cycle, giving a throughput of one transfer per 3 cycles.
- Each wait state adds one cycle. The wait counter clears on every entry to SETUP.
- rsp_rdata/rsp_err/rsp_timeout hold their values until the next response. rsp_valid is a pulse with no backpressure.
- Reset mid-transfer: psel and penable go to 0 at the reset edge, and no response is issued for the aborted transfer.

Decomposition:
- Shared package apb_pkg:
  - typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_t
  - default ADDR_W/DATA_W constants
- Optional sub-module apb_wait_timer: counter with clear, enable and expired output, parameterised on TIMEOUT, with TIMEOUT=0 meaning never expires.
- Everything else lives in one module.

Test Plan:
- Zero-wait write: cmd write addr=0x3, wdata=0xDEADBEEF, pready tied 1 -> psel high 2 cycles, penable high 1 cycle, pwdata=0xDEADBEEF, rsp_valid exactly 3 cycles after accept, rsp_err=0.
- Read with 2 wait states: cmd read addr=0x1, pready low 2 ACCESS cycles then high with prdata=0x12345678 -> paddr stable 4 cycles, rsp_rdata=0x12345678, rsp_valid 5 cycles after accept.
- Slave error: read addr=0x800, pslverr=1 with pready=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Timeout: TIMEOUT=4, pready held 0 -> exactly 4 ACCESS cycles, then psel=0, rsp_valid with rsp_err=1 and rsp_timeout=1; pready=1 on the 4th cycle instead -> normal completion.
- Reset mid-ACCESS: presetn=1 during wait states -> psel, penable and busy are 0 after that edge, no rsp_valid; next command runs normally.
- Back-to-back: cmd_valid held high for 3 writes (addr 0,1,2) -> three transfers, cmd_ready pulses every 3rd cycle, psel low exactly one cycle between transfers, 3 rsp_valid pulses in order.
